mul_issue_ctrl: RTL and testbench

Operand sequencer that sits directly upstream of the 8x8 sequential multiplier (`top`). It buffers incoming operand pairs in a small FIFO and issues them one at a time over the multiplier's a/b/start/done interface. It captures each 16-bit product into a single-entry output register with a valid/ready handshake. A watchdog aborts any multiplication whose done never arrives.

---
 rtl/mul_issue_ctrl_pkg.sv | 17 +
 rtl/mul_issue_ctrl_if.sv | 36 +++
 rtl/mul_issue_ctrl_sync_fifo.sv | 62 ++++++
 rtl/mul_issue_ctrl.sv | 109 ++++++++++
 tb/tb_mul_issue_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the multiplier front-end: operand widths, controller
// states and the default queue depth / watchdog limit.
package mul_pkg;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    localparam int DEFAULT_DEPTH   = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Operand-in, multiplier-side and product-out signals of mul_issue_ctrl.
// The master modport is the controller's view; slave is its environment.
interface mul_issue_ctrl_if #(
    parameter int W = mul_pkg::W
);
    localparam int PRODW = 2 * W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;

    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic             mul_start;
    logic             mul_done;
    logic [PRODW-1:0] mul_d_out;

    logic             out_valid;
    logic             out_ready;
    logic [PRODW-1:0] out_data;

    logic             busy;
    logic             err;

    modport master (
        input  in_valid, in_a, in_b, mul_done, mul_d_out, out_ready,
        output in_ready, mul_a, mul_b, mul_start, out_valid, out_data, busy, err
    );

    modport slave (
        output in_valid, in_a, in_b, mul_done, mul_d_out, out_ready,
        input  in_ready, mul_a, mul_b, mul_start, out_valid, out_data, busy, err
    );

endinterface

// File: rtl/mul_issue_ctrl_sync_fifo.sv
// Synchronous FIFO with count/full/empty; pointers wrap modulo DEPTH, so
// DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import mul_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage is not reset; resetting the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_issue_ctrl.sv
// Queues operand pairs and issues them one at a time to the sequential
// multiplier, capturing each product into a single valid/ready output slot.
module mul_issue_ctrl #(
    parameter int W       = mul_pkg::W,
    parameter int DEPTH   = mul_pkg::DEFAULT_DEPTH,
    parameter int TIMEOUT = mul_pkg::DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    mul_issue_ctrl_if.master  bus
);
    import mul_pkg::*;

    localparam int PAIRW = 2 * W;
    localparam int PRODW = 2 * W;
    localparam int WDW   = $clog2(TIMEOUT + 1);

    state_t               state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic                 start_q;
    logic                 out_valid_q;
    logic [PRODW-1:0]     out_data_q;
    logic                 err_q;
    logic [WDW-1:0]       wdog;

    logic [PAIRW-1:0]     head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 issue;

    // Issue is held off while a product is still waiting, so the slot is never overwritten.
    assign issue = (state == IDLE) && !fifo_empty && !out_valid_q;

    sync_fifo #(
        .WIDTH (PAIRW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.in_valid),
        .wdata ({bus.in_a, bus.in_b}),
        .pop   (issue),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.in_ready  = !rst && !fifo_full;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.mul_start = start_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE) || (fifo_count != '0);

    // Done takes priority over the watchdog when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            start_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            wdog        <= '0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        state      <= ISSUE;
                        {a_q, b_q} <= head;
                        start_q    <= 1'b1;
                        wdog       <= WDW'(1);
                    end
                end
                ISSUE: begin
                    if (bus.mul_done) begin
                        out_data_q  <= bus.mul_d_out;
                        out_valid_q <= 1'b1;
                        start_q     <= 1'b0;
                        state       <= GAP;
                    end else if (wdog == WDW'(TIMEOUT)) begin
                        err_q   <= 1'b1;
                        start_q <= 1'b0;
                        state   <= GAP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with a fixed-latency multiplier model and
// a monitor that records every accepted product.
module tb_mul_issue_ctrl;

    localparam int LAT = 10;

    logic clk;
    logic rst;
    logic model_en;
    logic auto_done;
    logic force_done;
    int   model_cnt;

    int vectors;
    int miscompares;

    logic [15:0] got_q[$];
    logic        prev_start;
    logic [7:0]  prev_a;
    logic [7:0]  prev_b;

    mul_issue_ctrl_if #(.W(8)) bus ();

    mul_issue_ctrl #(
        .W       (8),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mul_done  = auto_done || force_done;
    assign bus.mul_d_out = {8'h00, bus.mul_a} * {8'h00, bus.mul_b};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
        int waited;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        waited       = 0;
        while (!bus.in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!bus.in_ready) begin
            checkOutput("push_wait", 32'(bus.in_ready), 32'd1);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drainUntilIdle(input string tag);
        int i;
        for (i = 0; i < 400; i++) begin
            if (!bus.in_valid && !bus.busy && !bus.out_valid) break;
            tick();
        end
        checkOutput(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic checkProducts(input string tag, input logic [15:0] exp_q[$]);
        checkOutput({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                checkOutput($sformatf("%s_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            end
        end
    endtask

    // Fixed-latency multiplier: done pulses in the LAT-th cycle start is high.
    initial begin
        auto_done = 1'b0;
        model_cnt = 0;
        forever begin
            tick();
            if (bus.mul_start) model_cnt++;
            else model_cnt = 0;
            auto_done = model_en && bus.mul_start && (model_cnt == LAT);
        end
    end

    // Records accepted products and checks operands stay put while start is high.
    initial begin
        prev_start = 1'b0;
        prev_a     = '0;
        prev_b     = '0;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
            if (bus.mul_start && prev_start) begin
                checkOutput("a_stable", 32'(bus.mul_a), 32'(prev_a));
                checkOutput("b_stable", 32'(bus.mul_b), 32'(prev_b));
            end
            prev_start = bus.mul_start;
            prev_a     = bus.mul_a;
            prev_b     = bus.mul_b;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int waits;
        int n;
        int low_run;
        int gap;
        bit seen_fall;
        bit push_now;
        logic [15:0] exp_q[$];

        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        model_en     = 1'b1;
        force_done   = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.out_ready = 1'b0;

        $display("[TB] reset");
        repeat (3) tick();
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("rst_mul_start", 32'(bus.mul_start), 32'd0);
        checkOutput("rst_mul_a",     32'(bus.mul_a),     32'd0);
        checkOutput("rst_mul_b",     32'(bus.mul_b),     32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(bus.out_data),  32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("rst_err",       32'(bus.err),       32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_in_ready",  32'(bus.in_ready),  32'd1);

        $display("[TB] single op");
        applyStimulus(8'h81, 8'h13);
        checkOutput("single_start_t1", 32'(bus.mul_start), 32'd0);
        tick();
        checkOutput("single_start_t2", 32'(bus.mul_start), 32'd1);
        checkOutput("single_mul_a",    32'(bus.mul_a),     32'h81);
        checkOutput("single_mul_b",    32'(bus.mul_b),     32'h13);
        checkOutput("single_busy",     32'(bus.busy),      32'd1);
        waits = 0;
        while (!bus.out_valid && waits < 40) begin
            tick();
            waits++;
        end
        checkOutput("single_latency",  32'(waits),         32'd10);
        checkOutput("single_start_lo", 32'(bus.mul_start), 32'd0);
        checkOutput("single_data",     32'(bus.out_data),  32'h0993);
        repeat (3) tick();
        checkOutput("single_hold",     32'(bus.out_valid), 32'd1);
        checkOutput("single_idle",     32'(bus.busy),      32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checkOutput("single_consumed", 32'(bus.out_valid), 32'd0);
        exp_q = '{16'h0993};
        checkProducts("single_out", exp_q);
        got_q.delete();

        $display("[TB] back-to-back");
        bus.out_ready = 1'b1;
        applyStimulus(8'h81, 8'h13);
        applyStimulus(8'hF0, 8'h35);
        low_run   = 0;
        gap       = -1;
        seen_fall = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.mul_start) begin
                if (seen_fall && gap < 0) gap = low_run;
            end else if (gap < 0) begin
                seen_fall = 1'b1;
                low_run++;
            end
            if (!bus.busy && !bus.out_valid) break;
            tick();
        end
        checkOutput("b2b_idle", 32'(bus.busy), 32'd0);
        checkOutput("b2b_gap",  32'(gap),      32'd2);
        exp_q = '{16'h0993, 16'h31B0};
        checkProducts("b2b_out", exp_q);
        got_q.delete();

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(8'h02, 8'h03);
        applyStimulus(8'h10, 8'h10);
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'h07, 8'h09);
        applyStimulus(8'h80, 8'h03);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h0C;
        bus.in_b     = 8'h0D;
        repeat (20) tick();
        checkOutput("bp_full",      32'(bus.in_ready),  32'd0);
        checkOutput("bp_valid",     32'(bus.out_valid), 32'd1);
        checkOutput("bp_data",      32'(bus.out_data),  32'h0006);
        checkOutput("bp_start_lo",  32'(bus.mul_start), 32'd0);
        checkOutput("bp_busy",      32'(bus.busy),      32'd1);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("bp_ready_h1",  32'(bus.in_ready),  32'd0);
        tick();
        checkOutput("bp_ready_h2",  32'(bus.in_ready),  32'd1);
        for (int i = 0; i < 400; i++) begin
            push_now = bus.in_valid && bus.in_ready;
            if (!bus.in_valid && !bus.busy && !bus.out_valid) break;
            tick();
            if (push_now) bus.in_valid = 1'b0;
        end
        checkOutput("bp_pushed", 32'(bus.in_valid), 32'd0);
        checkOutput("bp_idle",   32'(bus.busy),     32'd0);
        exp_q = '{16'h0006, 16'h0100, 16'hFE01, 16'h003F, 16'h0180, 16'h009C};
        checkProducts("bp_out", exp_q);
        got_q.delete();

        $display("[TB] timeout");
        model_en = 1'b0;
        applyStimulus(8'h05, 8'h06);
        tick();
        n = 0;
        while (bus.mul_start && n < 100) begin
            n++;
            tick();
        end
        checkOutput("to_cycles",    32'(n),             32'd16);
        checkOutput("to_err",       32'(bus.err),       32'd1);
        checkOutput("to_no_valid",  32'(bus.out_valid), 32'd0);
        model_en = 1'b1;
        applyStimulus(8'h0B, 8'h0B);
        drainUntilIdle("to_idle");
        exp_q = '{16'h0079};
        checkProducts("to_out", exp_q);
        checkOutput("to_err_sticky", 32'(bus.err), 32'd1);
        got_q.delete();

        $display("[TB] reset mid-issue");
        model_en      = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(8'h11, 8'h22);
        applyStimulus(8'h33, 8'h44);
        applyStimulus(8'h55, 8'h66);
        checkOutput("mr_pre_start", 32'(bus.mul_start), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("mr_in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("mr_start",     32'(bus.mul_start), 32'd0);
        checkOutput("mr_mul_a",     32'(bus.mul_a),     32'd0);
        checkOutput("mr_mul_b",     32'(bus.mul_b),     32'd0);
        checkOutput("mr_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mr_out_data",  32'(bus.out_data),  32'd0);
        checkOutput("mr_busy",      32'(bus.busy),      32'd0);
        checkOutput("mr_err",       32'(bus.err),       32'd0);
        rst        = 1'b0;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        repeat (3) tick();
        checkOutput("mr_post_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mr_post_busy",  32'(bus.busy),      32'd0);
        checkOutput("mr_post_start", 32'(bus.mul_start), 32'd0);
        checkOutput("mr_post_ready", 32'(bus.in_ready),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
